// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: default widths and
// operand-fetch sequencer state encodings.
package lc3_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_CAP1   = 3'd2,
        S_CAP2   = 3'd3,
        S_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/reg_port_sequencer.sv
// Operand-fetch sequencer for a single-read-port register file,
// with write-back pass-through and same-cycle write forwarding.
module reg_port_sequencer
    import lc3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_sr1,
    input  logic [ADDR_W-1:0] req_sr2,
    input  logic              req_two,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_sr1,
    output logic [DATA_W-1:0] op_sr2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_out_reg,
    input  logic [DATA_W-1:0] rf_outdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_indata
);

    seq_state_e        state;
    seq_state_e        state_nx;
    logic [ADDR_W-1:0] sr1_q;
    logic [ADDR_W-1:0] sr2_q;
    logic              two_q;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_val;
    logic              launch;
    logic              accept;
    logic [DATA_W-1:0] cap_val;

    assign rf_we        = wb_valid;
    assign rf_write_reg = wb_reg;
    assign rf_indata    = wb_data;

    assign op_sr1 = sr1_val;
    assign op_sr2 = sr2_val;

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        op_valid   = 1'b0;
        rf_out_reg = '0;
        launch     = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                rf_out_reg = sr1_q;
                launch     = 1'b1;
                state_nx   = S_CAP1;
            end
            S_CAP1: begin
                rf_out_reg = sr2_q;
                launch     = two_q;
                state_nx   = two_q ? S_CAP2 : S_DONE;
            end
            S_CAP2: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                op_valid = 1'b1;
                if (op_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept  = req_valid && req_ready;
    // The read port returns pre-write data, so a same-cycle write wins.
    assign cap_val = fwd_hit ? fwd_data : rf_outdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr1_q <= '0;
            sr2_q <= '0;
            two_q <= 1'b0;
        end else if (accept) begin
            sr1_q <= req_sr1;
            sr2_q <= req_sr2;
            two_q <= req_two;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (launch) begin
            fwd_hit  <= wb_valid && (wb_reg == rf_out_reg);
            fwd_data <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr1_val <= '0;
            sr2_val <= '0;
        end else begin
            if (state == S_CAP1) begin
                sr1_val <= cap_val;
                if (!two_q)
                    sr2_val <= '0;
            end
            if (state == S_CAP2)
                sr2_val <= cap_val;
        end
    end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Randomized bench for reg_port_sequencer with a behavioural
// register file and a snapshot-based operand reference model.
module tb_reg_port_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sr1;
    logic [2:0]  req_sr2;
    logic        req_two;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_sr1;
    logic [15:0] op_sr2;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [2:0]  rf_out_reg;
    logic [15:0] rf_outdata;
    logic        rf_we;
    logic [2:0]  rf_write_reg;
    logic [15:0] rf_indata;

    logic [15:0] mem [8];
    logic [15:0] shadow [8];
    int          n_chk;
    int          n_pass;
    logic [15:0] got1;
    logic [15:0] got2;

    reg_port_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sr1(req_sr1), .req_sr2(req_sr2), .req_two(req_two),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_sr1(op_sr1), .op_sr2(op_sr2),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .rf_out_reg(rf_out_reg), .rf_outdata(rf_outdata),
        .rf_we(rf_we), .rf_write_reg(rf_write_reg),
        .rf_indata(rf_indata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file outside the DUT: synchronous write, registered read.
    always @(posedge clk) begin
        rf_outdata <= mem[rf_out_reg];
        if (rf_we)
            mem[rf_write_reg] <= rf_indata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        chk("wb_pass", {rf_we, 13'd0, rf_write_reg, rf_indata},
            {1'b1, 13'd0, r, d});
        shadow[r] = d;
        step();
        wb_valid = 1'b0;
    endtask

    // wb_cyc: cycle after acceptance carrying a write (0 = none).
    task automatic run_req(input logic [2:0] s1, input logic [2:0] s2,
                           input logic two, input int wb_cyc,
                           input logic [2:0] wreg, input logic [15:0] wdat,
                           input int hold);
        logic [15:0] exp1;
        logic [15:0] exp2;
        int          lat;
        lat  = two ? 4 : 3;
        exp1 = '0;
        exp2 = '0;
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_sr1   = s1;
        req_sr2   = s2;
        req_two   = two;
        step();
        req_valid = 1'b0;
        req_sr1   = 3'($urandom);
        req_sr2   = 3'($urandom);
        chk("no_early_valid", op_valid, 1'b0);
        for (int k = 1; k < lat; k++) begin
            if (k == wb_cyc) begin
                wb_valid = 1'b1;
                wb_reg   = wreg;
                wb_data  = wdat;
            end
            if (k == 1)
                exp1 = (k == wb_cyc && wreg == s1) ? wdat : shadow[s1];
            if (k == 2 && two)
                exp2 = (k == wb_cyc && wreg == s2) ? wdat : shadow[s2];
            if (k == wb_cyc)
                shadow[wreg] = wdat;
            step();
            wb_valid = 1'b0;
            if (k + 1 < lat)
                chk("op_valid_lo", op_valid, 1'b0);
        end
        chk("op_valid_lat", op_valid, 1'b1);
        chk("op_sr1", op_sr1, exp1);
        chk("op_sr2", op_sr2, exp2);
        chk("req_ready_busy", req_ready, 1'b0);
        chk("rf_out_done", rf_out_reg, 3'd0);
        got1 = op_sr1;
        got2 = op_sr2;
        for (int h = 0; h < hold; h++) begin
            if ($urandom_range(1, 0) == 1) begin
                wb_valid = 1'b1;
                wb_reg   = 3'($urandom);
                wb_data  = 16'($urandom);
                shadow[wb_reg] = wb_data;
            end
            step();
            wb_valid = 1'b0;
            chk("hold_valid", op_valid, 1'b1);
            chk("hold_data", {op_sr1, op_sr2}, {exp1, exp2});
            chk("hold_ready", req_ready, 1'b0);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        chk("post_valid", op_valid, 1'b0);
        chk("post_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  wr;
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sr1   = '0;
        req_sr2   = '0;
        req_two   = 1'b0;
        op_ready  = 1'b0;
        wb_valid  = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        for (int i = 0; i < 8; i++) begin
            mem[i]    = 16'h0;
            shadow[i] = 16'h0;
        end
        step();
        step();
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_ops", {op_sr1, op_sr2}, 32'h0);
        chk("rst_rf_out", rf_out_reg, 3'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", req_ready, 1'b1);

        for (int i = 0; i < 8; i++)
            write_reg(3'(i), 16'($urandom));

        write_reg(3'd3, 16'h1234);
        write_reg(3'd5, 16'h00FF);
        run_req(3'd3, 3'd5, 1'b1, 0, 3'd0, 16'h0, 0);
        chk("two_sr1", got1, 16'h1234);
        chk("two_sr2", got2, 16'h00FF);

        write_reg(3'd2, 16'hA5A5);
        run_req(3'd2, 3'd6, 1'b0, 0, 3'd0, 16'h0, 1);
        chk("one_sr1", got1, 16'hA5A5);
        chk("one_sr2", got2, 16'h0000);

        write_reg(3'd4, 16'h0001);
        run_req(3'd4, 3'd1, 1'b0, 1, 3'd4, 16'hBEEF, 0);
        chk("fwd_launch", got1, 16'hBEEF);

        write_reg(3'd4, 16'h0001);
        run_req(3'd4, 3'd1, 1'b0, 2, 3'd4, 16'hBEEF, 0);
        chk("snap_cap1", got1, 16'h0001);
        run_req(3'd4, 3'd1, 1'b0, 0, 3'd0, 16'h0, 0);
        chk("rf_updated", got1, 16'hBEEF);

        write_reg(3'd7, 16'h7777);
        run_req(3'd7, 3'd7, 1'b1, 2, 3'd7, 16'hC0DE, 0);
        chk("same_sr1", got1, 16'h7777);
        chk("same_sr2", got2, 16'hC0DE);

        run_req(3'd1, 3'd2, 1'b1, 0, 3'd0, 16'h0, 5);
        run_req(3'd3, 3'd0, 1'b0, 0, 3'd0, 16'h0, 0);

        write_reg(3'd6, 16'h6666);
        req_valid = 1'b1;
        req_sr1   = 3'd6;
        req_sr2   = 3'd6;
        req_two   = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        rst_n    = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 3'd0;
        wb_data  = 16'h0BAD;
        #1;
        chk("rst_mid_we", rf_we, 1'b1);
        chk("rst_mid_valid", op_valid, 1'b0);
        chk("rst_mid_sr1", op_sr1, 16'h0);
        shadow[0] = 16'h0BAD;
        step();
        wb_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_valid", op_valid, 1'b0);
        end
        chk("rst_idle_ready", req_ready, 1'b1);
        chk("rst_idle_out", rf_out_reg, 3'd0);
        chk("rst_sr1_zero", op_sr1, 16'h0);

        for (int n = 0; n < 60; n++) begin
            s1 = 3'($urandom);
            s2 = 3'($urandom);
            case ($urandom_range(2, 0))
                0: wr = s1;
                1: wr = s2;
                default: wr = 3'($urandom);
            endcase
            run_req(s1, s2, 1'($urandom), int'($urandom_range(4, 0)),
                    wr, 16'($urandom), int'($urandom_range(3, 0)));
            if ($urandom_range(3, 0) == 0)
                write_reg(3'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
